program_loader: RTL and testbench

Boot-time sequencer for the program RAM. It accepts a byte stream from the UART receiver, frames it as a 32-bit word-count header followed by a payload, packs the payload little-endian into 32-bit words, and writes them into consecutive program-RAM words. It holds the CPU off for the whole load. It sits between the CPU data port and the program RAM's CPU-side port, and passes CPU traffic straight through whenever no load is in progress.

---
 rtl/program_loader.sv | 149 ++++++++++++++
 tb/tb_program_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: frames a UART byte stream as a word-count header plus payload and writes it into program RAM.
// Holds the CPU for the whole load; the CPU's RAM port is a pass-through only while idle.
module program_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0002_0000,
    parameter int          MAX_WORDS = 4096
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        load_start_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    output logic        rx_ready_out,
    input  logic [31:0] cpu_addr_in,
    input  logic [31:0] cpu_data_in,
    input  logic [3:0]  cpu_write_enable_in,
    output logic [31:0] ram_addr_out,
    output logic [31:0] ram_data_out,
    output logic [3:0]  ram_write_enable_out,
    output logic        cpu_hold_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        error_out,
    output logic [12:0] words_loaded_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_len;
    logic [31:0] r_buf;
    logic [12:0] r_index;
    logic [12:0] r_words_loaded;
    logic        r_drain_cnt;
    logic        r_busy;
    logic        r_hold;
    logic        r_done;
    logic        r_error;

    logic        w_rx_fire;
    logic        w_last_byte;
    logic [31:0] w_len_full;
    logic        w_len_bad;
    logic        w_last_word;
    logic [31:0] w_write_addr;

    assign rx_ready_out = (r_state == S_LEN) || (r_state == S_DATA);
    assign w_rx_fire    = rx_valid_in & rx_ready_out;
    assign w_last_byte  = (r_byte_cnt == 2'd3);

    // Bytes shift in from the top, so the first byte lands in [7:0] after four shifts.
    assign w_len_full   = {rx_data_in, r_len[31:8]};
    assign w_len_bad    = (w_len_full == 32'd0) || (w_len_full > MAX_WORDS_W);
    assign w_last_word  = ({19'd0, r_index + 13'd1} == r_len);
    assign w_write_addr = ADDR_BASE + {17'd0, r_index, 2'b00};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (load_start_in) w_next_state = S_LEN;
            S_LEN:   if (w_rx_fire && w_last_byte) w_next_state = w_len_bad ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_fire && w_last_byte) w_next_state = S_WRITE;
            S_WRITE: w_next_state = w_last_word ? S_DRAIN : S_DATA;
            S_DRAIN: if (r_drain_cnt) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= S_IDLE;
            r_byte_cnt     <= 2'd0;
            r_len          <= 32'd0;
            r_buf          <= 32'd0;
            r_index        <= 13'd0;
            r_words_loaded <= 13'd0;
            r_drain_cnt    <= 1'b0;
            r_busy         <= 1'b0;
            r_hold         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            r_hold  <= (w_next_state != S_IDLE);
            r_done  <= (w_next_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (load_start_in) begin
                        r_byte_cnt     <= 2'd0;
                        r_len          <= 32'd0;
                        r_index        <= 13'd0;
                        r_words_loaded <= 13'd0;
                        r_error        <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (w_rx_fire) begin
                        r_len      <= w_len_full;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_last_byte && w_len_bad) r_error <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_buf      <= {rx_data_in, r_buf[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_index        <= r_index + 13'd1;
                    r_words_loaded <= r_words_loaded + 13'd1;
                    r_drain_cnt    <= 1'b0;
                end
                S_DRAIN: r_drain_cnt <= 1'b1;
                default: ;
            endcase
        end
    end

    // CPU writes arriving while the loader owns the port are dropped, never queued.
    always_comb begin
        if (r_state == S_IDLE) begin
            ram_addr_out         = cpu_addr_in;
            ram_data_out         = cpu_data_in;
            ram_write_enable_out = cpu_write_enable_in;
        end else begin
            ram_addr_out         = w_write_addr;
            ram_data_out         = r_buf;
            ram_write_enable_out = (r_state == S_WRITE) ? 4'b1111 : 4'b0000;
        end
    end

    assign busy_out         = r_busy;
    assign cpu_hold_out     = r_hold;
    assign done_out         = r_done;
    assign error_out        = r_error;
    assign words_loaded_out = r_words_loaded;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboarded bench for program_loader: a word-level model predicts RAM writes and done pulses from each byte stream.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_data = 32'd0;
    logic [3:0]  cpu_we = 4'd0;
    logic [31:0] ram_addr;
    logic [31:0] ram_data;
    logic [3:0]  ram_we;
    logic        hold, busy, done, err;
    logic [12:0] words_loaded;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int cyc; int words; } done_t;

    wr_t   wq[$];
    done_t dq[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    after_done = 1'b0;

    localparam logic [31:0] BASE = 32'h0002_0000;

    program_loader dut (
        .clk_in(clk), .rst_in(rst), .load_start_in(load_start),
        .rx_data_in(rx_data), .rx_valid_in(rx_valid), .rx_ready_out(rx_ready),
        .cpu_addr_in(cpu_addr), .cpu_data_in(cpu_data), .cpu_write_enable_in(cpu_we),
        .ram_addr_out(ram_addr), .ram_data_out(ram_data), .ram_write_enable_out(ram_we),
        .cpu_hold_out(hold), .busy_out(busy), .done_out(done), .error_out(err),
        .words_loaded_out(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes RAM or pulses done.
    always @(negedge clk) begin
        if (!rst) begin
            if (after_done) begin
                chk("hold_released_after_done", {hold, busy}, 2'b00);
                after_done = 1'b0;
            end
            if (rx_ready) chk("rx_ready_only_when_busy", {busy, done}, 2'b10);
            if (busy && ram_we != 4'b0000) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write_addr", ram_addr, 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("write_addr", ram_addr, w.addr);
                    chk("write_data", ram_data, w.data);
                    chk("write_we", ram_we, 4'b1111);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", done, 1'b0);
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
                    chk("done_words_loaded", words_loaded, d.words);
                    chk("hold_during_done", hold, 1'b1);
                    after_done = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int n;
        logic rdy;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = rx_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("rx_accept_timeout", n, 0);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start_accepted(output int edge_no);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        edge_no = cyc;
        chk("start_outputs", {busy, hold, rx_ready, err, words_loaded}, {4'b1110, 13'd0});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", busy, 1'b0);
    endtask

    // Model: word i of the payload is bytes 4i..4i+3, little-endian, at BASE + 4i.
    task automatic run_load(input logic [31:0] hdr, input int max_gap, input bit timed);
        bit   ok;
        int   s_edge;
        logic [7:0] pay[$];
        ok = (hdr != 0) && (hdr <= 32'd4096);
        if (ok) begin
            for (int i = 0; i < int'(hdr) * 4; i++) pay.push_back(8'($urandom));
            for (int i = 0; i < int'(hdr); i++) begin
                wr_t w;
                w.addr = BASE + 32'(i * 4);
                w.data = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
                wq.push_back(w);
            end
        end
        pulse_start_accepted(s_edge);
        if (ok) begin
            done_t d;
            d.cyc   = timed ? s_edge + 6 + 5 * int'(hdr) : -1;
            d.words = int'(hdr);
            dq.push_back(d);
        end
        for (int i = 0; i < 4; i++) send_byte(hdr[8*i +: 8], max_gap);
        for (int i = 0; i < pay.size(); i++) send_byte(pay[i], max_gap);
        wait_idle();
        chk("end_error", err, !ok);
        chk("end_words_loaded", words_loaded, ok ? hdr[12:0] : 13'd0);
        chk("end_hold", hold, 1'b0);
        chk("writes_outstanding", wq.size(), 0);
        chk("done_outstanding", dq.size(), 0);
    endtask

    initial begin
        int s_edge;
        int n;
        wr_t w;
        cpu_addr = 32'h1234_5678;
        cpu_data = 32'hDEAD_BEEF;
        repeat (3) tick();
        chk("reset_outputs", {rx_ready, hold, busy, done, err, words_loaded}, 18'd0);
        chk("reset_passthrough", {ram_addr, ram_data}, {32'h1234_5678, 32'hDEAD_BEEF});
        rst = 1'b0;
        tick();

        // Directed two-word load from the test plan, checked through the model.
        run_load(32'd2, 0, 1'b1);

        chk("idle_passthrough_pre", busy, 1'b0);
        cpu_addr = 32'h0002_0010;
        cpu_data = 32'hCAFE_F00D;
        cpu_we   = 4'b0011;
        #1;
        chk("idle_passthrough", {ram_addr, ram_data, ram_we}, {32'h0002_0010, 32'hCAFE_F00D, 4'b0011});
        cpu_we = 4'b0000;

        run_load(32'd0, 0, 1'b0);
        chk("error_sticky_idle", {err, busy}, 2'b10);
        run_load(32'd1, 0, 1'b1);
        run_load(32'h0000_1001, 0, 1'b0);
        run_load(32'd3, 5, 1'b0);
        run_load(32'd3, 0, 1'b1);

        // Second start mid-load is ignored; CPU writes during the load must not leak.
        cpu_addr = 32'h0002_0FF0;
        cpu_we   = 4'b1111;
        fork
            run_load(32'd3, 0, 1'b1);
            begin
                repeat (10) tick();
                load_start = 1'b1;
                tick();
                load_start = 1'b0;
            end
        join
        cpu_we = 4'b0000;

        // Start coinciding with done is ignored.
        fork
            run_load(32'd1, 0, 1'b1);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!done && n < 200);
                load_start = 1'b1;
                tick();
                load_start = 1'b0;
            end
        join
        repeat (2) tick();
        chk("start_on_done_ignored", {busy, hold}, 2'b00);

        for (int k = 0; k < 4; k++) run_load(32'($urandom_range(6, 1)), 3, 1'b0);

        // Reset after six payload bytes: only the first word reaches RAM.
        w.addr = BASE;
        w.data = 32'h4433_2211;
        wq.push_back(w);
        pulse_start_accepted(s_edge);
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd3 : 8'd0, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_midload", {busy, hold, rx_ready, done, words_loaded}, 17'd0);
        chk("reset_midload_writes", wq.size(), 0);
        tick();

        run_load(32'h0000_1000, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
